dkong_hs_ram_arb: RTL and testbench

// Arbitrates the shared work-RAM port between the main CPU and the hiscore engine.

---
 rtl/dkong_hs_ram_arb.sv | 133 +++++++++++++
 tb/tb_dkong_hs_ram_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dkong_hs_ram_arb.sv
// rtl/dkong_hs_ram_arb.sv - work-RAM port arbiter between the main CPU and the hiscore engine
// The engine gets the port only at CPU bus-cycle boundaries, or at once when the CPU is paused.
`timescale 1ns/1ps
module dkong_hs_ram_arb #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int RAM_LAT     = 1,
  parameter int CPU_MIN_GAP = 4
) (
  input  logic              I_CLK_24576M,
  input  logic              I_RESETn,
  input  logic              I_PAUSED,
  input  logic              I_CPU_CS,
  input  logic              I_CPU_WE,
  input  logic [ADDR_W-1:0] I_CPU_A,
  input  logic [DATA_W-1:0] I_CPU_DO,
  input  logic              I_CPU_CYC_END,
  output logic [DATA_W-1:0] O_CPU_DI,
  output logic              O_CPU_WAIT,
  input  logic              I_HS_ACCESS,
  input  logic              I_HS_WRITE,
  input  logic [ADDR_W-1:0] I_HS_ADDR,
  input  logic [DATA_W-1:0] I_HS_DATA,
  output logic [DATA_W-1:0] O_HS_DATA,
  output logic              O_HS_VALID,
  output logic              O_HS_GRANT,
  output logic [ADDR_W-1:0] O_RAM_A,
  output logic [DATA_W-1:0] O_RAM_D,
  output logic              O_RAM_WE,
  input  logic [DATA_W-1:0] I_RAM_Q
);

  localparam int GAP_W = (CPU_MIN_GAP < 1) ? 1 : $clog2(CPU_MIN_GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_owner_hs;
  logic [GAP_W-1:0]   r_gap;
  logic [RAM_LAT-1:0] r_rd_pipe;
  logic [DATA_W-1:0]  r_hs_data;
  logic               w_gap_zero;
  logic               w_rd_issue;
  logic               w_rd_done;

  assign w_gap_zero = (r_gap == '0);
  assign w_rd_issue = (r_state == S_GRANT) && !I_HS_WRITE;
  assign w_rd_done  = r_rd_pipe[RAM_LAT-1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (I_HS_ACCESS && w_gap_zero) begin
          w_next = I_PAUSED ? S_GRANT : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A withdrawn request wins over a coincident cycle end
        if (!I_HS_ACCESS) begin
          w_next = S_IDLE;
        end else if (I_CPU_CYC_END || I_PAUSED) begin
          w_next = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!I_HS_ACCESS) begin
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_state    <= S_IDLE;
      r_owner_hs <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_owner_hs <= (w_next == S_GRANT);
    end
  end

  // The CPU keeps the port for CPU_MIN_GAP clocks after each release
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_gap <= '0;
    end else if (r_state == S_RELEASE) begin
      r_gap <= GAP_W'(CPU_MIN_GAP);
    end else if (!w_gap_zero) begin
      r_gap <= r_gap - GAP_W'(1);
    end
  end

  // Read tracker keeps shifting after GRANT ends so the last read still returns
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_rd_pipe <= '0;
      r_hs_data <= '0;
    end else begin
      r_rd_pipe[0] <= w_rd_issue;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
      if (w_rd_done) begin
        r_hs_data <= I_RAM_Q;
      end
    end
  end

  assign O_HS_VALID = w_rd_done;
  assign O_HS_DATA  = w_rd_done ? I_RAM_Q : r_hs_data;
  assign O_HS_GRANT = r_owner_hs;
  assign O_CPU_WAIT = (r_state == S_DRAIN) || ((r_state == S_GRANT) && !I_PAUSED);
  assign O_CPU_DI   = I_RAM_Q;

  assign O_RAM_A  = r_owner_hs ? I_HS_ADDR  : I_CPU_A;
  assign O_RAM_D  = r_owner_hs ? I_HS_DATA  : I_CPU_DO;
  assign O_RAM_WE = r_owner_hs ? I_HS_WRITE : (I_CPU_CS && I_CPU_WE);

endmodule

// File: tb/tb_dkong_hs_ram_arb.sv
// tb/tb_dkong_hs_ram_arb.sv - directed bench for the hiscore/CPU work-RAM arbiter
// Drives inputs 1ns after the rising edge and checks on the falling edge.
`timescale 1ns/1ps
module tb_dkong_hs_ram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        paused, cpu_cs, cpu_we, cyc_end, hs_access, hs_write;
  logic [15:0] cpu_a, hs_addr, ram_a;
  logic [7:0]  cpu_do, hs_data_in, cpu_di, hs_data, ram_d, ram_q;
  logic        cpu_wait, hs_valid, hs_grant, ram_we;
  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dkong_hs_ram_arb dut (
    .I_CLK_24576M (clk),
    .I_RESETn     (rst_n),
    .I_PAUSED     (paused),
    .I_CPU_CS     (cpu_cs),
    .I_CPU_WE     (cpu_we),
    .I_CPU_A      (cpu_a),
    .I_CPU_DO     (cpu_do),
    .I_CPU_CYC_END(cyc_end),
    .O_CPU_DI     (cpu_di),
    .O_CPU_WAIT   (cpu_wait),
    .I_HS_ACCESS  (hs_access),
    .I_HS_WRITE   (hs_write),
    .I_HS_ADDR    (hs_addr),
    .I_HS_DATA    (hs_data_in),
    .O_HS_DATA    (hs_data),
    .O_HS_VALID   (hs_valid),
    .O_HS_GRANT   (hs_grant),
    .O_RAM_A      (ram_a),
    .O_RAM_D      (ram_d),
    .O_RAM_WE     (ram_we),
    .I_RAM_Q      (ram_q)
  );

  // One-cycle-latency synchronous RAM
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h6100] = 8'hA5;
    mem[16'h6010] = 8'h77;
    rst_n = 1'b0; paused = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cyc_end = 1'b0;
    hs_access = 1'b0; hs_write = 1'b0; cpu_a = 16'h0; hs_addr = 16'h0;
    cpu_do = 8'h0; hs_data_in = 8'h0;

    repeat (2) nxt();
    mid();
    chk("rst_grant", hs_grant, 0);
    chk("rst_wait", cpu_wait, 0);
    chk("rst_valid", hs_valid, 0);
    chk("rst_hsdata", hs_data, 0);
    chk("rst_we", ram_we, 0);
    nxt();
    rst_n = 1'b1;
    nxt();

    // Paused CPU: immediate grant, read of 0x6100
    paused = 1'b1; hs_access = 1'b1; hs_addr = 16'h6100;
    mid(); chk("t1_grant_a", hs_grant, 0); nxt();
    hs_access = 1'b0;
    mid();
    chk("t1_grant_b", hs_grant, 1);
    chk("t1_wait_b", cpu_wait, 0);
    chk("t1_addr_b", ram_a, 32'h6100);
    chk("t1_we_b", ram_we, 0);
    nxt();
    mid();
    chk("t1_valid_c", hs_valid, 1);
    chk("t1_data_c", hs_data, 32'hA5);
    chk("t1_grant_c", hs_grant, 0);
    nxt();
    mid();
    chk("t1_valid_d", hs_valid, 0);
    chk("t1_hold_d", hs_data, 32'hA5);
    nxt();
    paused = 1'b0;
    repeat (6) nxt();

    // Running CPU: drain with CPU write, CYC_END at drain entry ignored
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_a = 16'h6000; cpu_do = 8'h55;
    hs_access = 1'b1; hs_addr = 16'h6010; cyc_end = 1'b1;
    mid(); chk("t2_wait0", cpu_wait, 0); chk("t2_we0", ram_we, 1); nxt();
    cyc_end = 1'b0;
    mid(); chk("t2_wait1", cpu_wait, 1); chk("t2_grant1", hs_grant, 0); nxt();
    for (int k = 2; k <= 4; k++) begin
      mid();
      chk("t2_wait_drain", cpu_wait, 1);
      chk("t2_addr_drain", ram_a, 32'h6000);
      chk("t2_we_drain", ram_we, 1);
      nxt();
    end
    cyc_end = 1'b1;
    mid(); chk("t2_wait5", cpu_wait, 1); chk("t2_grant5", hs_grant, 0); nxt();
    cyc_end = 1'b0;
    mid();
    chk("t2_grant6", hs_grant, 1);
    chk("t2_wait6", cpu_wait, 1);
    chk("t2_addr6", ram_a, 32'h6010);
    chk("t2_we6", ram_we, 0);
    nxt();
    chk("t2_mem6000", {24'h0, mem[16'h6000]}, 32'h55);

    // Engine write overrides a simultaneous CPU write
    hs_write = 1'b1; hs_addr = 16'h6020; hs_data_in = 8'h3C;
    cpu_a = 16'h6020; cpu_do = 8'h99;
    mid();
    chk("t3_valid7", hs_valid, 1);
    chk("t3_data7", hs_data, 32'h77);
    chk("t3_we7", ram_we, 1);
    chk("t3_d7", ram_d, 32'h3C);
    chk("t3_addr7", ram_a, 32'h6020);
    nxt();
    hs_write = 1'b0; hs_access = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
    mid(); chk("t3_grant8", hs_grant, 1); chk("t3_valid8", hs_valid, 0); nxt();
    chk("t3_mem6020", {24'h0, mem[16'h6020]}, 32'h3C);

    // Release then immediate re-request: gap holds the engine off
    hs_access = 1'b1;
    mid();
    chk("t4_grant9", hs_grant, 0);
    chk("t4_wait9", cpu_wait, 0);
    chk("t4_valid9", hs_valid, 1);
    chk("t4_data9", hs_data, 32'h3C);
    nxt();
    for (int k = 10; k <= 14; k++) begin
      mid(); chk("t4_wait_gap", cpu_wait, 0); chk("t4_grant_gap", hs_grant, 0); nxt();
    end
    cyc_end = 1'b1;
    mid(); chk("t4_wait15", cpu_wait, 1); chk("t4_grant15", hs_grant, 0); nxt();
    cyc_end = 1'b0; paused = 1'b1;
    mid(); chk("t4_grant16", hs_grant, 1); chk("t4_wait16", cpu_wait, 0); nxt();
    paused = 1'b0;
    mid(); chk("t4_grant17", hs_grant, 1); chk("t4_wait17", cpu_wait, 1); nxt();
    hs_access = 1'b0;
    repeat (8) nxt();

    // Request withdrawn during DRAIN
    hs_access = 1'b1;
    mid(); chk("t5_wait0", cpu_wait, 0); nxt();
    hs_access = 1'b0;
    mid(); chk("t5_wait1", cpu_wait, 1); chk("t5_we1", ram_we, 0); nxt();
    mid(); chk("t5_wait2", cpu_wait, 0); chk("t5_grant2", hs_grant, 0); nxt();
    mid(); chk("t5_grant3", hs_grant, 0); chk("t5_we3", ram_we, 0); nxt();

    // Pause during DRAIN grants, then reset with a read in flight
    hs_access = 1'b1; hs_addr = 16'h6100;
    mid(); nxt();
    paused = 1'b1;
    mid(); chk("t6_wait1", cpu_wait, 1); chk("t6_grant1", hs_grant, 0); nxt();
    mid(); chk("t6_grant2", hs_grant, 1); chk("t6_wait2", cpu_wait, 0); nxt();
    mid();
    chk("t6_valid3", hs_valid, 1);
    chk("t6_data3", hs_data, 32'hA5);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", hs_grant, 0);
    chk("t6_rst_wait", cpu_wait, 0);
    chk("t6_rst_valid", hs_valid, 0);
    chk("t6_rst_data", hs_data, 0);
    chk("t6_rst_we", ram_we, 0);
    nxt();
    hs_access = 1'b0; paused = 1'b0;
    nxt();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid(); chk("t6_post_valid", hs_valid, 0); chk("t6_post_grant", hs_grant, 0); nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
